// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32IM memory-access stage: load/store op codes
// and the stage FSM state type.
package rv32_mem_pkg;

  // DATA_MEM_READ_IN encodings; any other code means "no load".
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b101;
  localparam logic [2:0] LD_LHU  = 3'b110;

  // DATA_MEM_WRITE_IN encodings.
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_e;

  // True for the five load codes that actually perform a read.
  function automatic logic is_load(input logic [2:0] op);
    logic legal;
    case (op)
      LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Purely combinational lane logic for the memory-access stage: decodes the
// op, flags misalignment, builds byte enables and replicated store data, and
// extracts/extends the addressed lane of a returned read word.
import rv32_mem_pkg::*;

module load_store_align (
  input  logic [2:0]  read_op_i,
  input  logic [1:0]  write_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  ld_op_i,      // load code latched at request time
  input  logic [1:0]  ld_lane_i,    // address low bits latched at request time
  input  logic [31:0] rdata_i,
  output logic        is_read_o,
  output logic        is_write_o,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ext_o
);

  logic [1:0] size_code;  // 0 byte, 1 half, 2 word
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  // Decode op width, alignment, byte enables and store replication.
  always_comb begin
    is_read_o    = is_load(read_op_i);
    // A read wins when both read and write are requested.
    is_write_o   = !is_read_o && (write_op_i != ST_NONE);
    size_code    = 2'd0;
    misaligned_o = 1'b0;
    be_o         = 4'b0000;
    wdata_o      = '0;

    if (is_read_o) begin
      case (read_op_i)
        LD_LH, LD_LHU: size_code = 2'd1;
        LD_LW:         size_code = 2'd2;
        default:       size_code = 2'd0;
      endcase
    end else begin
      case (write_op_i)
        ST_SH:   size_code = 2'd1;
        ST_SW:   size_code = 2'd2;
        default: size_code = 2'd0;
      endcase
    end

    if (is_read_o || is_write_o) begin
      case (size_code)
        2'd1: begin
          misaligned_o = addr_lo_i[0];
          be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end
        2'd2: begin
          misaligned_o = |addr_lo_i;
          be_o         = 4'b1111;
        end
        default: be_o = 4'b0001 << addr_lo_i;
      endcase
    end

    if (is_write_o) begin
      case (write_op_i)
        ST_SB:   wdata_o = {4{store_data_i[7:0]}};
        ST_SH:   wdata_o = {2{store_data_i[15:0]}};
        default: wdata_o = store_data_i;
      endcase
    end
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    case (ld_lane_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = ld_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (ld_op_i)
      LD_LB:   ext_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  ext_o = {24'b0, byte_sel};
      LD_LH:   ext_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  ext_o = {16'b0, half_sel};
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32IM pipeline: turns load/store control into a
// word-aligned req/ack transaction, stalls the pipe with BUSYWAIT while it is
// outstanding, and registers the extended load result.
// Optional access timeout: define MEM_ACCESS_TIMEOUT_EN.
import rv32_mem_pkg::*;

module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [2:0]  DATA_MEM_READ_IN,
  input  logic [1:0]  DATA_MEM_WRITE_IN,
  input  logic [31:0] ALU_RESULT_IN,
  input  logic [31:0] DATA2_IN,
  output logic [31:0] DATA_MEM_RESULT_OUT,
  output logic        BUSYWAIT,
  output logic        MISALIGNED,
  output logic        ACCESS_FAULT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  mem_state_e  state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [31:0] result_q;
  logic [2:0]  ld_op_q;
  logic [1:0]  ld_lane_q;

  logic        is_read;
  logic        is_write;
  logic        op_valid;
  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ext_data;
  logic        start;
  logic        timeout;

  load_store_align u_align (
    .read_op_i    (DATA_MEM_READ_IN),
    .write_op_i   (DATA_MEM_WRITE_IN),
    .addr_lo_i    (ALU_RESULT_IN[1:0]),
    .store_data_i (DATA2_IN),
    .ld_op_i      (ld_op_q),
    .ld_lane_i    (ld_lane_q),
    .rdata_i      (MEM_RDATA),
    .is_read_o    (is_read),
    .is_write_o   (is_write),
    .misaligned_o (misaligned),
    .be_o         (be),
    .wdata_o      (wdata),
    .ext_o        (ext_data)
  );

  assign op_valid = is_read | is_write;
  assign start    = (state_q == S_IDLE) && op_valid && !misaligned;
  assign BUSYWAIT = start || (state_q == S_ACCESS);
  assign MISALIGNED = misaligned;

  // A misaligned op reads as 0 in the same cycle it is presented.
  assign DATA_MEM_RESULT_OUT = ((state_q == S_IDLE) && misaligned) ? '0 : result_q;

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_BE    = mem_be_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            fault_q;

  assign timeout = (state_q == S_ACCESS) && !MEM_ACK &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Count un-acknowledged ACCESS cycles; cleared whenever outside ACCESS.
  always_ff @(posedge CLOCK) begin
    if (RESET || (state_q != S_ACCESS)) begin
      cnt_q <= '0;
    end else if (!MEM_ACK) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // One-cycle fault pulse, visible during the DONE cycle after a timeout.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= timeout;
    end
  end

  assign ACCESS_FAULT = fault_q;
`else
  assign timeout      = 1'b0;
  assign ACCESS_FAULT = 1'b0;
`endif

  // Stage FSM with registered request signals and load result.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      result_q    <= '0;
      ld_op_q     <= LD_NONE;
      ld_lane_q   <= 2'b00;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_ACCESS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_write;
            mem_addr_q  <= {ALU_RESULT_IN[31:2], 2'b00};
            mem_wdata_q <= wdata;
            mem_be_q    <= be;
            ld_op_q     <= is_read ? DATA_MEM_READ_IN : LD_NONE;
            ld_lane_q   <= ALU_RESULT_IN[1:0];
          end else if (misaligned) begin
            result_q <= '0;
          end
        end
        S_ACCESS: begin
          // An ACK in the final counted cycle still completes normally.
          if (MEM_ACK) begin
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
            if (!mem_we_q) begin
              result_q <= ext_data;
            end
          end else if (timeout) begin
            mem_req_q <= 1'b0;
            result_q  <= '0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases followed by random
// loads/stores, checked against an arithmetic reference model.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [2:0]  DATA_MEM_READ_IN;
  logic [1:0]  DATA_MEM_WRITE_IN;
  logic [31:0] ALU_RESULT_IN;
  logic [31:0] DATA2_IN;
  logic [31:0] DATA_MEM_RESULT_OUT;
  logic        BUSYWAIT;
  logic        MISALIGNED;
  logic        ACCESS_FAULT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_res = '0;

  always #5 CLOCK = ~CLOCK;

  mem_access_stage #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK               (CLOCK),
    .RESET               (RESET),
    .DATA_MEM_READ_IN    (DATA_MEM_READ_IN),
    .DATA_MEM_WRITE_IN   (DATA_MEM_WRITE_IN),
    .ALU_RESULT_IN       (ALU_RESULT_IN),
    .DATA2_IN            (DATA2_IN),
    .DATA_MEM_RESULT_OUT (DATA_MEM_RESULT_OUT),
    .BUSYWAIT            (BUSYWAIT),
    .MISALIGNED          (MISALIGNED),
    .ACCESS_FAULT        (ACCESS_FAULT),
    .MEM_REQ             (MEM_REQ),
    .MEM_WE              (MEM_WE),
    .MEM_ADDR            (MEM_ADDR),
    .MEM_WDATA           (MEM_WDATA),
    .MEM_BE              (MEM_BE),
    .MEM_RDATA           (MEM_RDATA),
    .MEM_ACK             (MEM_ACK)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal_rd(input logic [2:0] rd);
    return (rd == 3'd1) || (rd == 3'd2) || (rd == 3'd3) || (rd == 3'd5) || (rd == 3'd6);
  endfunction

  // Reference load result: shift the addressed byte/half down, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] rd, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    case (rd)
      3'd1: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
      3'd2: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
      3'd5: v = v & 32'hFF;
      3'd6: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // Present one op, answer the request after 'waits' idle ACCESS cycles, and
  // check the whole transaction.
  task automatic run_op(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                        input logic [31:0] d2, input logic [31:0] word, input int waits);
    bit is_rd, is_wr, mis, go, tmo;
    int sz, busy, acc, exp_busy;
    logic [31:0] exp_be, exp_wd;
    is_rd = legal_rd(rd);
    is_wr = !is_rd && (wr != 2'd0);
    if (is_rd) sz = (rd == 3'd2 || rd == 3'd6) ? 2 : (rd == 3'd3) ? 4 : 1;
    else       sz = (wr == 2'd2) ? 2 : (wr == 2'd3) ? 4 : 1;
    mis = (is_rd || is_wr) && ((addr % sz) != 0);
    go  = (is_rd || is_wr) && !mis;
    tmo = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    tmo = go && (waits >= int'(TO));
`endif
    exp_busy = !go ? 0 : tmo ? 1 + int'(TO) : 2 + waits;
    exp_be   = (((32'd1 << sz) - 1) << (addr % 4)) & 32'hF;
    exp_wd   = (sz == 1) ? (d2 & 32'hFF) * 32'h01010101 :
               (sz == 2) ? (d2 & 32'hFFFF) * 32'h00010001 : d2;

    DATA_MEM_READ_IN  = rd;
    DATA_MEM_WRITE_IN = wr;
    ALU_RESULT_IN     = addr;
    DATA2_IN          = d2;
    MEM_RDATA         = word;
    MEM_ACK           = 1'b0;
    #1;
    chk("misaligned", MISALIGNED, mis);
    chk("busy_start", BUSYWAIT, go);

    busy = 0;
    acc  = 0;
    while (BUSYWAIT && busy < 200) begin
      busy++;
      @(posedge CLOCK); #1;
      if (BUSYWAIT) begin
        if (acc == 0) begin
          chk("req", MEM_REQ, 1'b1);
          chk("we", MEM_WE, is_wr);
          chk("addr", MEM_ADDR, addr - (addr % 4));
          chk("be", MEM_BE, exp_be);
          if (is_wr) chk("wdata", MEM_WDATA, exp_wd);
        end
        MEM_ACK = (acc == waits);
        acc++;
      end else begin
        MEM_ACK = 1'b0;
      end
    end
    MEM_ACK = 1'b0;
    chk("busy_cycles", busy, exp_busy);

    if (go) begin
      if (tmo)        exp_res = '0;
      else if (is_rd) exp_res = model_load(rd, addr, word);
      chk("req_done", MEM_REQ, 1'b0);
      chk("fault", ACCESS_FAULT, tmo);
      chk("result", DATA_MEM_RESULT_OUT, exp_res);
    end else begin
      if (mis) exp_res = '0;
      chk("result_idle", DATA_MEM_RESULT_OUT, exp_res);
      @(posedge CLOCK); #1;
      chk("req_idle", MEM_REQ, 1'b0);
      chk("busy_idle", BUSYWAIT, 1'b0);
      chk("result_idle2", DATA_MEM_RESULT_OUT, exp_res);
    end

    DATA_MEM_READ_IN  = 3'd0;
    DATA_MEM_WRITE_IN = 2'd0;
    @(posedge CLOCK); #1;
    chk("fault_clear", ACCESS_FAULT, 1'b0);
    chk("result_hold", DATA_MEM_RESULT_OUT, exp_res);
  endtask

  initial begin
    RESET             = 1'b1;
    DATA_MEM_READ_IN  = 3'd0;
    DATA_MEM_WRITE_IN = 2'd0;
    ALU_RESULT_IN     = '0;
    DATA2_IN          = '0;
    MEM_RDATA         = '0;
    MEM_ACK           = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    chk("rst_req", MEM_REQ, 1'b0);
    chk("rst_we", MEM_WE, 1'b0);
    chk("rst_be", MEM_BE, 4'b0000);
    chk("rst_result", DATA_MEM_RESULT_OUT, 32'h0);
    chk("rst_busy", BUSYWAIT, 1'b0);
    chk("rst_fault", ACCESS_FAULT, 1'b0);

    // Directed cases.
    run_op(3'd3, 2'd0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);  // LW
    run_op(3'd1, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);  // LB
    run_op(3'd5, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);  // LBU
    run_op(3'd6, 2'd0, 32'h0000_0102, 32'h0, 32'h80FF_0000, 2);  // LHU
    run_op(3'd0, 2'd2, 32'h0000_0206, 32'h1234_ABCD, 32'h0, 3);  // SH
    run_op(3'd0, 2'd1, 32'h0000_0301, 32'hAABB_CC5A, 32'h0, 0);  // SB
    run_op(3'd3, 2'd0, 32'h0000_0102, 32'h0, 32'h1111_1111, 0);  // LW misaligned
    run_op(3'd0, 2'd3, 32'h0000_0402, 32'h5555_5555, 32'h0, 0);  // SW misaligned
    run_op(3'd0, 2'd0, 32'h0000_0500, 32'h0, 32'h0, 0);          // no op
    run_op(3'd2, 2'd3, 32'h0000_0602, 32'h9999_9999, 32'h8001_7FFF, 0);  // read wins
    run_op(3'd4, 2'd0, 32'h0000_0700, 32'h0, 32'h0, 0);          // illegal read code

    // Reset in ACCESS with the ACK still pending; a late ACK must be ignored.
    run_op(3'd3, 2'd0, 32'h0000_0800, 32'h0, 32'h0BAD_F00D, 0);
    DATA_MEM_READ_IN = 3'd3;
    ALU_RESULT_IN    = 32'h0000_0900;
    MEM_RDATA        = 32'hFFFF_FFFF;
    @(posedge CLOCK); #1;
    chk("pre_rst_req", MEM_REQ, 1'b1);
    RESET            = 1'b1;
    DATA_MEM_READ_IN = 3'd0;
    @(posedge CLOCK); #1;
    RESET   = 1'b0;
    exp_res = '0;
    chk("midrst_req", MEM_REQ, 1'b0);
    chk("midrst_busy", BUSYWAIT, 1'b0);
    chk("midrst_result", DATA_MEM_RESULT_OUT, exp_res);
    MEM_ACK = 1'b1;
    @(posedge CLOCK); #1;
    MEM_ACK = 1'b0;
    chk("late_ack_result", DATA_MEM_RESULT_OUT, exp_res);
    chk("late_ack_req", MEM_REQ, 1'b0);
    @(posedge CLOCK); #1;
    chk("late_ack_busy", BUSYWAIT, 1'b0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    run_op(3'd3, 2'd0, 32'h0000_0A00, 32'h0, 32'h1234_5678, 0);
    run_op(3'd3, 2'd0, 32'h0000_0A04, 32'h0, 32'hCAFE_CAFE, 1000);  // never acked
`endif

    // Random loads/stores, including misaligned and illegal codes.
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
             $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory Access (MEM) stage logic of the RV32IM pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts the stage's load/store control into a word-aligned request/acknowledge transaction with byte enables to data memory.
- Sign- or zero-extends load data and drives BUSYWAIT to stall all pipeline registers while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, ACCESS-state cycles without MEM_ACK before a fault (used only with the optional feature)

Ports:
- CLOCK  in  1  single stage clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- DATA_MEM_READ_IN  in  3  000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU; others = none
- DATA_MEM_WRITE_IN  in  2  00 none, 01 SB, 10 SH, 11 SW
- ALU_RESULT_IN  in  32  effective byte address
- DATA2_IN  in  32  store data (rs2)
- DATA_MEM_RESULT_OUT  out  32  extended load data to the MEM/WB register
- BUSYWAIT  out  1  stall request to all pipeline registers
- MISALIGNED  out  1  current op is misaligned; no access performed
- ACCESS_FAULT  out  1  one-cycle pulse on timeout (optional feature)
- MEM_REQ  out  1  memory request, held until acknowledged
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ
- MEM_ADDR  out  32  {ALU_RESULT_IN[31:2],2'b00}
- MEM_WDATA  out  32  lane-replicated store data
- MEM_BE  out  4  byte enables
- MEM_RDATA  in  32  read word, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion strobe

Behaviour:
- Reset is synchronous and active-high: FSM goes to IDLE; MEM_REQ, MEM_WE, MEM_BE, ACCESS_FAULT and the timeout counter clear to 0; DATA_MEM_RESULT_OUT clears to 0. Reset mid-transaction abandons it with no write-back; a late MEM_ACK in IDLE is ignored.
- op_valid = legal read code OR write != 00. If both read and write are set, the read is performed and the write is ignored.
- Misaligned rule:
  - LH/LHU/SH with addr[0] = 1
  - LW/SW with addr[1:0] != 00
  - MISALIGNED is combinational. No request is issued, BUSYWAIT stays 0, and the result is 0.
- FSM states:
  - IDLE: if op_valid and not misaligned, BUSYWAIT = 1 (combinational) and go to ACCESS. On the same edge, register MEM_REQ = 1, MEM_WE, MEM_ADDR, MEM_BE and MEM_WDATA. Otherwise stay in IDLE with BUSYWAIT = 0.
  - ACCESS: MEM_REQ = 1 and BUSYWAIT = 1. On MEM_ACK, capture the extended MEM_RDATA into DATA_MEM_RESULT_OUT (reads only), clear MEM_REQ and go to DONE.
  - DONE: BUSYWAIT = 0, so the pipeline advances on this edge. Result is held. Return to IDLE unconditionally.
- Latency: minimum 3 cycles per memory op (ACK in the first ACCESS cycle); each ACK wait cycle adds 1. Non-memory ops cost 0 stall cycles.
- Byte enables: SB = 0001 << addr[1:0]; SH = 0011 << addr[1]*2; SW = 1111.
- Store data: SB replicates {4{d[7:0]}}; SH replicates {2{d[15:0]}}; SW passes d unchanged.
- Load extension: byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
- Outside DONE, DATA_MEM_RESULT_OUT holds the last captured value. The register is only sampled downstream when WB selects memory.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. At TIMEOUT_CYCLES without MEM_ACK:
  - clear MEM_REQ, force the result to 0, pulse ACCESS_FAULT for 1 cycle, go to DONE
  - the counter clears on IDLE entry
- Undefined: the block waits indefinitely, ACCESS_FAULT is tied 0, and no counter is present.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - load codes (LD_NONE, LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU)
  - store codes (ST_NONE, ST_SB, ST_SH, ST_SW)
  - FSM state enum (S_IDLE, S_ACCESS, S_DONE)
- One natural sub-module: load_store_align. It is purely combinational and generates MEM_BE, MEM_WDATA, the extended load data and MISALIGNED. The top holds the FSM, request registers and counter.

Test Plan:
- LW, addr 0x100, MEM_RDATA = 0xDEADBEEF, ACK in 1st ACCESS cycle -> BUSYWAIT high for 2 cycles, result 0xDEADBEEF, MEM_ADDR 0x100, MEM_BE 1111.
- LB at 0x103, word 0x80FF_0000 -> result 0xFFFFFF80; LBU same -> 0x00000080; LHU at 0x102 -> 0x000080FF.
- SH at 0x206, DATA2_IN = 0x1234ABCD -> MEM_WE = 1, MEM_ADDR 0x204, MEM_BE 1100, MEM_WDATA 0xABCDABCD; ACK after 3 waits -> BUSYWAIT high for 5 cycles.
- LW at 0x102 -> MISALIGNED = 1, MEM_REQ never rises, BUSYWAIT = 0, result 0.
- RESET asserted in ACCESS with ACK pending -> next cycle IDLE, MEM_REQ = 0, result 0; a later ACK is ignored.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ACK -> ACCESS_FAULT pulses after 4 ACCESS cycles, result 0, FSM returns to IDLE via DONE.
